// File: rtl/rotor_stepper.sv
// rotor_stepper
// Holds the left/middle/right rotor positions and applies Enigma stepping
// (including the middle-rotor double step) once per accepted keypress.
// The updated positions are presented with a valid/ready handshake so the
// downstream encipher path consumes each position set exactly once.
//
// Parameters:
//   LEFT_TYPE, MID_TYPE, RIGHT_TYPE : rotor type per slot
//                                     (00=I, 01=II, 10=III, 11=identity)
// Ports:
//   clk                      : clock, rising-edge
//   rst                      : synchronous active-high reset
//   load, load_l/m/r         : load ground setting (values >25 wrap by -26)
//   key_valid / key_ready    : keypress handshake, one step per accept
//   pos_l, pos_m, pos_r      : current positions 0..25
//   pos_valid / pos_ready    : position-set handshake toward the rotors
module rotor_stepper #(
   parameter logic [1:0] LEFT_TYPE  = 2'b00,
   parameter logic [1:0] MID_TYPE   = 2'b01,
   parameter logic [1:0] RIGHT_TYPE = 2'b10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [4:0] load_l,
   input  logic [4:0] load_m,
   input  logic [4:0] load_r,
   input  logic       key_valid,
   output logic       key_ready,
   output logic [4:0] pos_l,
   output logic [4:0] pos_m,
   output logic [4:0] pos_r,
   output logic       pos_valid,
   input  logic       pos_ready
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t     state_reg, state_next;
   logic [4:0] pos_l_reg, pos_l_next;
   logic [4:0] pos_m_reg, pos_m_next;
   logic [4:0] pos_r_reg, pos_r_next;

   // True when a rotor of type t sits at its turnover position.
   // The identity type has no notch at all.
   function automatic logic at_notch(input logic [4:0] p, input logic [1:0] t);
      logic hit;
      case (t)
         2'b00:   hit = (p == 5'd16);
         2'b01:   hit = (p == 5'd4);
         2'b10:   hit = (p == 5'd21);
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

   function automatic logic [4:0] inc26(input logic [4:0] p);
      return (p >= 5'd25) ? 5'd0 : p + 5'd1;
   endfunction

   // A 5-bit load value can exceed 25 by at most 6, so one subtraction folds it.
   function automatic logic [4:0] fold26(input logic [4:0] v);
      return (v > 5'd25) ? v - 5'd26 : v;
   endfunction

   logic right_notch;
   logic mid_notch;

   assign right_notch = at_notch(pos_r_reg, RIGHT_TYPE);
   assign mid_notch   = at_notch(pos_m_reg, MID_TYPE);

   always_comb begin
      state_next = state_reg;
      pos_l_next = pos_l_reg;
      pos_m_next = pos_m_reg;
      pos_r_next = pos_r_reg;

      if (load) begin
         // Load wins over a simultaneous keypress and drops any pending set.
         state_next = IDLE;
         pos_l_next = fold26(load_l);
         pos_m_next = fold26(load_m);
         pos_r_next = fold26(load_r);
      end else begin
         case (state_reg)
            IDLE: begin
               if (key_valid) begin
                  state_next = HOLD;
                  pos_r_next = inc26(pos_r_reg);
                  // Middle notch also moves the middle rotor: double step.
                  if (right_notch || mid_notch)
                     pos_m_next = inc26(pos_m_reg);
                  if (mid_notch)
                     pos_l_next = inc26(pos_l_reg);
               end
            end
            HOLD: begin
               if (pos_ready)
                  state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         pos_l_reg <= 5'd0;
         pos_m_reg <= 5'd0;
         pos_r_reg <= 5'd0;
      end else begin
         state_reg <= state_next;
         pos_l_reg <= pos_l_next;
         pos_m_reg <= pos_m_next;
         pos_r_reg <= pos_r_next;
      end
   end

   assign key_ready = (state_reg == IDLE);
   assign pos_valid = (state_reg == HOLD);
   assign pos_l     = pos_l_reg;
   assign pos_m     = pos_m_reg;
   assign pos_r     = pos_r_reg;

endmodule

// File: tb/tb_rotor_stepper.sv
// Directed testbench for rotor_stepper. Two instances share the stimulus:
// one with rotor types I/II/III, one with all-identity rotors (no notches).
module tb_rotor_stepper;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [4:0] load_l, load_m, load_r;
   logic       key_valid;
   logic       pos_ready;

   logic       key_ready, pos_valid;
   logic [4:0] pos_l, pos_m, pos_r;
   logic       id_key_ready, id_pos_valid;
   logic [4:0] id_pos_l, id_pos_m, id_pos_r;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rotor_stepper #(.LEFT_TYPE(2'b00), .MID_TYPE(2'b01), .RIGHT_TYPE(2'b10)) dut (
      .clk(clk), .rst(rst), .load(load),
      .load_l(load_l), .load_m(load_m), .load_r(load_r),
      .key_valid(key_valid), .key_ready(key_ready),
      .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
      .pos_valid(pos_valid), .pos_ready(pos_ready)
   );

   rotor_stepper #(.LEFT_TYPE(2'b11), .MID_TYPE(2'b11), .RIGHT_TYPE(2'b11)) dut_id (
      .clk(clk), .rst(rst), .load(load),
      .load_l(load_l), .load_m(load_m), .load_r(load_r),
      .key_valid(key_valid), .key_ready(id_key_ready),
      .pos_l(id_pos_l), .pos_m(id_pos_m), .pos_r(id_pos_r),
      .pos_valid(id_pos_valid), .pos_ready(pos_ready)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_pos(input string tag, input int l, input int m, input int r);
      check({tag, ".l"}, pos_l, l);
      check({tag, ".m"}, pos_m, m);
      check({tag, ".r"}, pos_r, r);
   endtask

   task automatic do_load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
      load = 1'b1; load_l = l; load_m = m; load_r = r;
      tick();
      load = 1'b0;
   endtask

   // Accept a keypress, hold one cycle without pos_ready, then acknowledge.
   task automatic press(input string tag, input int l, input int m, input int r);
      key_valid = 1'b1;
      pos_ready = 1'b0;
      tick();
      key_valid = 1'b0;
      check({tag, ".pos_valid"}, pos_valid, 1);
      check({tag, ".key_ready"}, key_ready, 0);
      check_pos(tag, l, m, r);
      tick();
      check({tag, ".hold"}, pos_valid, 1);
      pos_ready = 1'b1;
      tick();
      pos_ready = 1'b0;
      check({tag, ".ack_ready"}, key_ready, 1);
      check({tag, ".ack_valid"}, pos_valid, 0);
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; load_l = 0; load_m = 0; load_r = 0;
      key_valid = 1'b0; pos_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_pos("reset", 0, 0, 0);
      check("reset.key_ready", key_ready, 1);
      check("reset.pos_valid", pos_valid, 0);

      press("first", 0, 0, 1);

      // ADU -> ADV -> AEW -> BFX (double step)
      do_load(5'd0, 5'd3, 5'd20);
      check_pos("load_adu", 0, 3, 20);
      check("load_adu.pos_valid", pos_valid, 0);
      press("adv", 0, 3, 21);
      press("aew", 0, 4, 22);
      press("bfx", 1, 5, 23);

      // Identity rotors: wrap only, no turnover
      do_load(5'd25, 5'd25, 5'd25);
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      check("ident.l", id_pos_l, 25);
      check("ident.m", id_pos_m, 25);
      check("ident.r", id_pos_r, 0);
      check("ident.pos_valid", id_pos_valid, 1);

      do_load(5'd0, 5'd0, 5'd21);
      press("right_notch", 0, 1, 22);
      do_load(5'd0, 5'd4, 5'd0);
      press("mid_notch", 1, 5, 1);

      // Back-pressure: key_valid held, pos_ready low for 5 cycles
      do_load(5'd0, 5'd0, 5'd0);
      key_valid = 1'b1;
      pos_ready = 1'b0;
      tick();
      check_pos("bp_accept", 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("bp_hold%0d.pos_valid", i), pos_valid, 1);
         check($sformatf("bp_hold%0d.r", i), pos_r, 1);
      end
      pos_ready = 1'b1;
      tick();
      pos_ready = 1'b0;
      check("bp_release.key_ready", key_ready, 1);
      check("bp_release.r", pos_r, 1);
      tick();
      key_valid = 1'b0;
      check("bp_next.r", pos_r, 2);
      check("bp_next.pos_valid", pos_valid, 1);
      pos_ready = 1'b1;
      tick();
      pos_ready = 1'b0;
      check("bp_done.r", pos_r, 2);

      // Full-rate: key_ready toggles 0,1,0,1 with both handshakes held high
      do_load(5'd0, 5'd0, 5'd0);
      key_valid = 1'b1;
      pos_ready = 1'b1;
      tick(); check("rate1.key_ready", key_ready, 0); check("rate1.r", pos_r, 1);
      tick(); check("rate2.key_ready", key_ready, 1); check("rate2.r", pos_r, 1);
      tick(); check("rate3.key_ready", key_ready, 0); check("rate3.r", pos_r, 2);
      tick(); check("rate4.key_ready", key_ready, 1); check("rate4.r", pos_r, 2);
      key_valid = 1'b0;
      pos_ready = 1'b0;

      // Load values above 25 fold down by 26
      do_load(5'd27, 5'd3, 5'd30);
      check_pos("fold", 1, 3, 4);

      // Load and keypress together: load wins, no step
      key_valid = 1'b1;
      do_load(5'd2, 5'd2, 5'd2);
      key_valid = 1'b0;
      check_pos("load_vs_key", 2, 2, 2);
      check("load_vs_key.pos_valid", pos_valid, 0);
      check("load_vs_key.key_ready", key_ready, 1);

      // Reset while holding a position set
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      check_pos("pre_rst", 2, 2, 3);
      check("pre_rst.pos_valid", pos_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_pos("rst_hold", 0, 0, 0);
      check("rst_hold.key_ready", key_ready, 1);
      check("rst_hold.pos_valid", pos_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rotor_stepper.md
# rotor_stepper

Sequential position controller that sits directly upstream of the three `rotor` instances. It holds the left, middle and right rotor positions and applies Enigma stepping once per accepted keypress, including the middle-rotor double step. It presents the updated 5-bit positions to the `n` inputs of the rotor chain, with a valid/ready handshake so the downstream encipher path can consume each position set exactly once.

## Interface
- `LEFT_TYPE`, default 2'b00: rotor type in the left slot (00=I, 01=II, 10=III, 11=none/identity).
- `MID_TYPE`, default 2'b01: rotor type in the middle slot, same encoding.
- `RIGHT_TYPE`, default 2'b10: rotor type in the right slot, same encoding.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `load`  in  1  load the initial positions (ground setting) this cycle.
- `load_l`, `load_m`, `load_r`  in  5 each  initial positions for load.
- `key_valid`  in  1  keypress request; one step per accepted request.
- `key_ready`  out  1  block can accept a keypress.
- `pos_l`, `pos_m`, `pos_r`  out  5 each  current positions 0..25; drive rotor `n`.
- `pos_valid`  out  1  positions reflect a completed step, awaiting consumption.
- `pos_ready`  in  1  downstream has consumed the positions.

## Operation
- Notch (turnover) positions per type: I=16 (Q), II=4 (E), III=21 (V); type 11 has no notch and never causes turnover.
- FSM with two states:
  - IDLE: `key_ready`=1, `pos_valid`=0.
  - HOLD: `key_ready`=0, `pos_valid`=1.
- IDLE and `key_valid`=1: perform one step, go to HOLD.
- HOLD and `pos_ready`=1: go to IDLE. `pos_ready` is ignored in IDLE.
- Step rule, evaluated on pre-step positions, all three updates in the same edge:
  - The right rotor always advances by 1.
  - The middle rotor advances if the right rotor is at its notch OR the middle rotor is at its notch (double step).
  - The left rotor advances if the middle rotor is at its notch.
- Each advance is (p+1) mod 26: 25 wraps to 0, with no carry beyond the notch rules.
- `load`=1 (any state): positions take `load_l/m/r`, FSM goes to IDLE, and any pending `pos_valid` is dropped.
  - A load value v>25 is stored as v-26.
  - `load` has priority over a simultaneous keypress; that keypress is not accepted and no step occurs.
- Positions change only on reset, load, or an accepted keypress. They are stable throughout HOLD.
- `key_ready` and `pos_valid` are decoded from FSM state only, never combinationally from inputs.

## Timing
- Reset takes effect at the first clock edge with `rst`=1 and overrides `load` and keypresses. State after reset:
  - `pos_l`=`pos_m`=`pos_r`=0.
  - FSM in IDLE, so `key_ready`=1 and `pos_valid`=0.
- Reset asserted mid-HOLD: the next edge returns to the reset state and the pending position set is discarded.
- Latency: a keypress accepted at edge k updates the positions and raises `pos_valid` after edge k.
- Keypress-to-keypress throughput:
  - Minimum 2 cycles: accept, then HOLD with `pos_ready`=1.
  - With `pos_ready` held high, `key_ready` toggles 1,0,1,0.
- `key_valid` held high while `key_ready`=0 is not accepted. It is accepted on the first IDLE edge.
- Load latency: positions equal the load values after the edge where `load`=1. `pos_valid` is 0 from that edge on.

## Test plan
- Reset, then one keypress with I/II/III → positions (0,0,1), `pos_valid`=1 until `pos_ready`, then `key_ready`=1.
- Load (0,3,20) (ADU), three keypresses each acknowledged → ADV (0,3,21), AEW (0,4,22), BFX (1,5,23). This is the double step.
- Load (25,25,25) with types 11/11/11, one keypress → (25,25,0). Wrap occurs, no notch effects.
- Load (0,0,21) with I/II/III, keypress → (0,1,22). Load (0,4,0), keypress → (1,5,1).
- Back-pressure: hold `pos_ready`=0 for 5 cycles with `key_valid`=1. Require `pos_valid` to stay 1, positions to stay stable, and no extra step. Then raise `pos_ready` → exactly one more step on the next accept.
- Edge cases:
  - Load with value 27 → stored as 1.
  - `load` and `key_valid` in the same cycle → load values kept, no step.
  - `rst` during HOLD → (0,0,0), IDLE.
